adder_seq_arbiter: RTL and testbench
====================================

Name: adder_seq_arbiter

Overview:
Shares one sequential adder between NUM_REQ requesters.
- Round-robin arbitration, one accepted operation per cycle.
- Drives the adder's operand/valid/enable inputs directly.
- Tracks the owner of each in-flight operation in a tag pipeline and steers the adder result back to that requester.
- Sits between the PE-side requesters and a single shared adder instance in the reduction path.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- DATA_WIDTH, 16: operand/result width; matches the adder.
- ADDER_LATENCY, 1: cycles from adder input to adder o_valid; sets the tag pipeline depth (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_en  in  1  arbiter enable; no new grants while low
- i_pause  in  1  request to stop granting and drain
- i_req_valid  in  NUM_REQ  per-requester operation valid
- i_req_data  in  NUM_REQ*2*DATA_WIDTH  requester k at [k*2*DATA_WIDTH +: 2*DATA_WIDTH]; low half = b, high half = a
- o_req_ready  out  NUM_REQ  one-hot grant; transfer when valid & ready
- o_rsp_valid  out  NUM_REQ  one-hot result valid for the owning requester
- o_rsp_data  out  DATA_WIDTH  result; shared by all requesters, qualified by o_rsp_valid
- o_add_valid  out  2  to adder i_valid
- o_add_data_bus  out  2*DATA_WIDTH  to adder i_data_bus
- o_add_en  out  1  to adder i_en
- i_add_valid  in  1  from adder o_valid
- i_add_data_bus  in  DATA_WIDTH  from adder o_data_bus
- o_busy  out  1  high while any tag stage is valid
- o_paused  out  1  high in PAUSED
- o_err  out  1  sticky: adder result arrived with no valid tag
- o_grant_cnt  out  32  total accepted operations (see Optional Feature)

Behaviour:
- Reset (async, rst=1): FSM=RUN, RR pointer=NUM_REQ-1 (requester 0 wins first), all tag stages invalid, o_err=0, o_grant_cnt=0. All outputs 0 during reset.
- Grant (combinational):
  - Only in RUN with i_en=1 and i_pause=0.
  - Search i_req_valid starting at pointer+1, wrapping modulo NUM_REQ; the first set bit wins.
  - o_req_ready = one-hot of the winner; all zero when there is no request or the grant is gated.
  - A requester must hold its valid and data stable until ready is seen.
- Pointer update: set to the winner index on an accepted grant; unchanged otherwise.
- Adder drive:
  - On grant: o_add_valid=2'b11 and o_add_data_bus = winner's data, muxed combinationally.
  - Otherwise: o_add_valid=2'b00 and o_add_data_bus=0.
  - o_add_en = i_en OR o_busy, so an in-flight result is never zeroed by i_en falling.
- Tag pipeline:
  - ADDER_LATENCY stages of {valid, index}, shifting every cycle.
  - Stage 0 loads {1, winner} on an accepted grant, else {0, x}.
- Response:
  - o_rsp_valid[k] = i_add_valid & last_tag.valid & (last_tag.index==k).
  - o_rsp_data = i_add_data_bus, combinational pass-through.
  - Accept-to-response latency = ADDER_LATENCY cycles.
  - Responses have no backpressure; requesters must always accept them.
- Error: i_add_valid=1 with last_tag invalid -> o_err set, held until reset; the result is dropped.
- FSM:
  - RUN -> DRAIN when i_pause=1. No grant is issued in any cycle with i_pause=1.
  - DRAIN -> PAUSED when the tag pipeline is empty. In-flight results are still returned during DRAIN.
  - DRAIN -> RUN if i_pause falls before the pipeline is empty.
  - PAUSED -> RUN when i_pause=0. o_paused=1 only in PAUSED.
- Arithmetic: the adder wraps modulo 2^DATA_WIDTH. The arbiter does not modify data.
- Reset mid-operation: in-flight tags are discarded. A result emerging after reset is ignored and does not set o_err; o_err is cleared by reset.

Optional Feature:
- Macro ADDER_SEQ_ARBITER_GRANT_CNT_EN.
- Defined: o_grant_cnt increments by 1 per accepted grant and saturates at 32'hFFFFFFFF.
- Undefined: no counter logic; o_grant_cnt is tied to 0.

Test Plan:
- Single requester: req0 a=3, b=5 -> o_req_ready=0001 in cycle 0; o_rsp_valid=0001 and o_rsp_data=8 at cycle 1 (ADDER_LATENCY=1).
- All four valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; each response routed to the matching index one cycle later.
- Requesters 1 and 3 valid after reset -> grant 1, then 3, then 1; requesters 0 and 2 never granted.
- i_pause raised one cycle after a grant -> no further ready; DRAIN returns the pending result; o_paused=1 the next cycle; lowering i_pause resumes granting.
- Wrap: a=16'hFFFF, b=2 -> o_rsp_data=16'h0001; i_en dropped right after the grant -> o_add_en stays 1 and the result is still returned.
- Spurious i_add_valid with no grant -> o_err=1 and stays 1; rst asserted mid-stream -> all outputs 0 immediately; o_grant_cnt=0 when the macro is defined.

Source files
------------

// File: rtl/adder_seq_arbiter_if.sv
// Requester-side and adder-side bus between the PE requesters, the arbiter and the shared adder.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface adder_seq_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]              i_req_valid;
  logic [NUM_REQ*2*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]              o_req_ready;
  logic [NUM_REQ-1:0]              o_rsp_valid;
  logic [DATA_WIDTH-1:0]           o_rsp_data;
  logic [1:0]                      o_add_valid;
  logic [2*DATA_WIDTH-1:0]         o_add_data_bus;
  logic                            o_add_en;
  logic                            i_add_valid;
  logic [DATA_WIDTH-1:0]           i_add_data_bus;

  modport slave (
    input  i_req_valid, i_req_data, i_add_valid, i_add_data_bus,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_add_valid, o_add_data_bus, o_add_en
  );

  modport master (
    output i_req_valid, i_req_data, i_add_valid, i_add_data_bus,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_add_valid, o_add_data_bus, o_add_en
  );
endinterface

// File: rtl/adder_seq_arbiter.sv
// Round-robin arbiter sharing one pipelined adder between NUM_REQ requesters, with owner-tag routing.
// Optional saturating grant counter is enabled by defining ADDER_SEQ_ARBITER_GRANT_CNT_EN.
module adder_seq_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDER_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_pause,
  adder_seq_arbiter_if.slave bus,
  output logic               o_busy,
  output logic               o_paused,
  output logic               o_err,
  output logic [31:0]        o_grant_cnt
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int PAIR_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PAUSED} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [IDX_W-1:0]         r_ptr;
  logic                     r_tag_vld [ADDER_LATENCY];
  logic [IDX_W-1:0]         r_tag_idx [ADDER_LATENCY];
  logic [ADDER_LATENCY-1:0] r_ign;
  logic                     r_err;

  logic [PAIR_W-1:0]        w_req_pair [NUM_REQ];
  logic [ADDER_LATENCY-1:0] w_tag_vld_vec;
  logic                     w_busy;
  logic                     w_last_vld;
  logic [IDX_W-1:0]         w_last_idx;
  logic                     w_ign;
  logic                     w_gate;
  logic                     w_found;
  logic                     w_grant;
  logic [IDX_W-1:0]         w_win;
  logic [IDX_W-1:0]         w_cand;
  logic [NUM_REQ-1:0]       w_ready;
  logic [NUM_REQ-1:0]       w_rsp_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_pair[gi] = bus.i_req_data[gi*PAIR_W +: PAIR_W];
    end
    for (gi = 0; gi < ADDER_LATENCY; gi++) begin : g_tag_vec
      assign w_tag_vld_vec[gi] = r_tag_vld[gi];
    end
  endgenerate

  assign w_busy     = |w_tag_vld_vec;
  assign w_last_vld = r_tag_vld[ADDER_LATENCY-1];
  assign w_last_idx = r_tag_idx[ADDER_LATENCY-1];
  assign w_ign      = r_ign[ADDER_LATENCY-1];
  assign w_gate     = !rst && (r_state == ST_RUN) && i_en && !i_pause;
  assign w_grant    = w_gate && w_found;

  // Search starts one past the last winner and wraps, so the previous winner is checked last.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = r_ptr;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_cand = (w_cand == IDX_W'(NUM_REQ - 1)) ? '0 : w_cand + IDX_W'(1);
      if (!w_found && bus.i_req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_grant) w_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_rsp_valid = '0;
    if (bus.i_add_valid && w_last_vld) w_rsp_valid[w_last_idx] = 1'b1;
  end

  assign bus.o_req_ready    = w_ready;
  assign bus.o_rsp_valid    = w_rsp_valid;
  assign bus.o_rsp_data     = rst ? '0 : bus.i_add_data_bus;
  assign bus.o_add_valid    = w_grant ? 2'b11 : 2'b00;
  assign bus.o_add_data_bus = w_grant ? w_req_pair[w_win] : '0;
  // Keeping the adder enabled while tags are in flight stops i_en from stranding a result.
  assign bus.o_add_en       = !rst && (i_en || w_busy);
  assign o_busy             = w_busy;
  assign o_paused           = (r_state == ST_PAUSED);
  assign o_err              = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < ADDER_LATENCY; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_idx[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_grant;
      r_tag_idx[0] <= w_win;
      for (int s = 1; s < ADDER_LATENCY; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (w_grant) begin
      r_ptr <= w_win;
    end
  end

  // Results already inside the adder at reset time surface during the first ADDER_LATENCY
  // cycles afterwards; they belong to discarded tags and must not be flagged as errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ign <= '1;
      r_err <= 1'b0;
    end else begin
      r_ign <= r_ign << 1;
      if (bus.i_add_valid && !w_last_vld && !w_ign) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    if (i_pause) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!i_pause)     w_state_next = ST_RUN;
        else if (!w_busy) w_state_next = ST_PAUSED;
      end
      ST_PAUSED: if (!i_pause) w_state_next = ST_RUN;
      default:   w_state_next = ST_RUN;
    endcase
  end

`ifdef ADDER_SEQ_ARBITER_GRANT_CNT_EN
  logic [31:0] r_grant_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt <= '0;
    end else if (w_grant && (r_grant_cnt != 32'hFFFF_FFFF)) begin
      r_grant_cnt <= r_grant_cnt + 32'd1;
    end
  end

  assign o_grant_cnt = r_grant_cnt;
`else
  assign o_grant_cnt = '0;
`endif
endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Self-checking bench for adder_seq_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model, with a behavioural pipelined adder attached.
`timescale 1ns/1ps
module tb_adder_seq_arbiter;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int LAT = 1;
  localparam int S_RUN = 0, S_DRAIN = 1, S_PAUSED = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_pause = 1'b0;
  logic        o_busy, o_paused, o_err;
  logic [31:0] o_grant_cnt;

  adder_seq_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  adder_seq_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDER_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_pause    (i_pause),
    .bus        (bus),
    .o_busy     (o_busy),
    .o_paused   (o_paused),
    .o_err      (o_err),
    .o_grant_cnt(o_grant_cnt)
  );

  always #5 clk = ~clk;

  // Shared adder: not reset, so a result in flight at reset time survives it.
  logic          add_v [LAT] = '{default: 1'b0};
  logic [DW-1:0] add_d [LAT] = '{default: '0};
  logic          spur = 1'b0;

  always @(posedge clk) begin
    if (bus.o_add_en) begin
      for (int s = LAT - 1; s > 0; s--) begin
        add_v[s] <= add_v[s-1];
        add_d[s] <= add_d[s-1];
      end
      add_v[0] <= &bus.o_add_valid;
      add_d[0] <= bus.o_add_data_bus[2*DW-1:DW] + bus.o_add_data_bus[DW-1:0];
    end
  end

  assign bus.i_add_valid    = add_v[LAT-1] | spur;
  assign bus.i_add_data_bus = add_d[LAT-1];

  // Reference model state
  typedef struct {bit v; int idx; logic [DW-1:0] sum;} ent_t;
  ent_t   m_q[$];
  int     m_ptr, m_state, m_ign;
  bit     m_err;
  longint m_cnt;

  logic [DW-1:0] td_a [N];
  logic [DW-1:0] td_b [N];
  logic [N-1:0]  td_v;
  bit            td_spur;

  logic [N-1:0]    exp_ready, exp_rsp_valid;
  logic [DW-1:0]   exp_rsp_data;
  logic [1:0]      exp_add_valid;
  logic [2*DW-1:0] exp_add_data;
  logic            exp_add_en, exp_busy, exp_paused, exp_err;
  logic [31:0]     exp_cnt;
  int              exp_win;
  bit              exp_grant;

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    ent_t e;
    e.v = 1'b0; e.idx = 0; e.sum = '0;
    m_q.delete();
    for (int s = 0; s < LAT; s++) m_q.push_back(e);
    m_ptr = N - 1; m_state = S_RUN; m_ign = LAT; m_err = 1'b0; m_cnt = 0;
  endtask

  // Computes this cycle's expected outputs, then advances the model across the next edge.
  task automatic model_cycle();
    ent_t front, ne;
    bit   busy;
    front = m_q[0];
    busy = 1'b0;
    foreach (m_q[j]) busy |= m_q[j].v;
    void'(m_q.pop_front());
    exp_grant = 1'b0; exp_win = 0;
    if (m_state == S_RUN && i_en && !i_pause) begin
      for (int off = 1; off <= N; off++) begin
        if (!exp_grant && td_v[(m_ptr + off) % N]) begin
          exp_grant = 1'b1;
          exp_win   = (m_ptr + off) % N;
        end
      end
    end
    exp_ready = '0;
    if (exp_grant) exp_ready[exp_win] = 1'b1;
    exp_add_valid = exp_grant ? 2'b11 : 2'b00;
    exp_add_data  = exp_grant ? {td_a[exp_win], td_b[exp_win]} : '0;
    exp_rsp_valid = '0;
    if (front.v) exp_rsp_valid[front.idx] = 1'b1;
    exp_rsp_data = front.sum;
    exp_busy     = busy;
    exp_paused   = (m_state == S_PAUSED);
    exp_add_en   = i_en || busy;
    exp_err      = m_err;
`ifdef ADDER_SEQ_ARBITER_GRANT_CNT_EN
    exp_cnt = (m_cnt >= 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_cnt[31:0];
`else
    exp_cnt = '0;
`endif
    if (td_spur && !front.v && m_ign == 0) m_err = 1'b1;
    if (m_ign > 0) m_ign--;
    ne.v = exp_grant; ne.idx = exp_win; ne.sum = td_a[exp_win] + td_b[exp_win];
    m_q.push_back(ne);
    if (exp_grant) begin
      m_ptr = exp_win;
      m_cnt++;
    end
    case (m_state)
      S_RUN:    if (i_pause) m_state = S_DRAIN;
      S_DRAIN:  if (!i_pause) m_state = S_RUN; else if (!busy) m_state = S_PAUSED;
      default:  if (!i_pause) m_state = S_RUN;
    endcase
  endtask

  task automatic drive(input logic [N-1:0] v, input bit en, input bit pause);
    @(negedge clk);
    td_v = v; i_en = en; i_pause = pause;
    bus.i_req_valid = v;
    for (int k = 0; k < N; k++) bus.i_req_data[k*2*DW +: 2*DW] = {td_a[k], td_b[k]};
    spur = td_spur;
    model_cycle();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; td_v = '0; td_spur = 1'b0; spur = 1'b0;
    bus.i_req_valid = '0; i_en = 1'b0; i_pause = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.i_req_valid = '1; bus.i_req_data = '1; i_en = 1'b1;
    #3;
    checks++;
    if ({bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_data, bus.o_add_valid, bus.o_add_data_bus,
         bus.o_add_en, o_busy, o_paused, o_err, o_grant_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rsp_v=%b add_v=%b add_en=%b busy=%b paused=%b err=%b cnt=%0d, required all 0",
               bus.o_req_ready, bus.o_rsp_valid, bus.o_add_valid, bus.o_add_en, o_busy, o_paused, o_err, o_grant_cnt);
    end
    apply_reset();
    drive(4'b0000, 1'b1, 1'b0);
    checks++;
    if ({bus.o_req_ready, o_busy, o_paused, o_err, o_grant_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b busy=%b paused=%b err=%b cnt=%0d, required 0", bus.o_req_ready, o_busy, o_paused, o_err, o_grant_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    apply_reset();
    td_a[0] = 16'd3; td_b[0] = 16'd5;
    drive(4'b0001, 1'b1, 1'b0);
    checks++;
    if (bus.o_req_ready !== 4'b0001 || bus.o_add_valid !== 2'b11 || bus.o_add_data_bus !== {16'd3, 16'd5}) begin
      errors++;
      $display("FAIL single_grant: ready=%b add_v=%b add_data=%h, required 0001 11 00030005", bus.o_req_ready, bus.o_add_valid, bus.o_add_data_bus);
    end
    drive(4'b0000, 1'b1, 1'b0);
    checks++;
    if (bus.o_rsp_valid !== 4'b0001 || bus.o_rsp_data !== 16'd8) begin
      errors++;
      $display("FAIL single_rsp: rsp_v=%b data=%0d, required 0001 8", bus.o_rsp_valid, bus.o_rsp_data);
    end
    $display("test_single done: rsp_v=%b data=%0d", bus.o_rsp_valid, bus.o_rsp_data);
  endtask

  task automatic test_all_rr();
    logic [N-1:0] want;
    apply_reset();
    for (int k = 0; k < N; k++) begin
      td_a[k] = 16'($urandom); td_b[k] = 16'($urandom);
    end
    for (int i = 0; i <= 8; i++) begin
      drive((i < 8) ? 4'b1111 : 4'b0000, 1'b1, 1'b0);
      want = (i < 8) ? (4'b0001 << (i % 4)) : 4'b0000;
      checks++;
      if (bus.o_req_ready !== want) begin
        errors++;
        $display("FAIL rr_ready cyc %0d: got %b required %b", i, bus.o_req_ready, want);
      end
      if (i > 0) begin
        want = 4'b0001 << ((i - 1) % 4);
        checks++;
        if (bus.o_rsp_valid !== want || bus.o_rsp_data !== exp_rsp_data) begin
          errors++;
          $display("FAIL rr_rsp cyc %0d: rsp_v=%b data=%h required %b %h", i, bus.o_rsp_valid, bus.o_rsp_data, want, exp_rsp_data);
        end
      end
      $display("rr cyc %0d: ready=%b rsp_v=%b", i, bus.o_req_ready, bus.o_rsp_valid);
    end
  endtask

  task automatic test_sparse();
    logic [N-1:0] seq [3];
    seq[0] = 4'b0010; seq[1] = 4'b1000; seq[2] = 4'b0010;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1010, 1'b1, 1'b0);
      checks++;
      if (bus.o_req_ready !== seq[i]) begin
        errors++;
        $display("FAIL sparse_ready cyc %0d: got %b required %b", i, bus.o_req_ready, seq[i]);
      end
      $display("sparse cyc %0d: ready=%b", i, bus.o_req_ready);
    end
  endtask

  task automatic test_pause();
    bit pz [6];
    pz[0] = 0; pz[1] = 1; pz[2] = 1; pz[3] = 1; pz[4] = 0; pz[5] = 0;
    apply_reset();
    td_a[0] = 16'd100; td_b[0] = 16'd23;
    for (int i = 0; i < 6; i++) begin
      drive(4'b0001, 1'b1, pz[i]);
      checks++;
      if (bus.o_req_ready !== exp_ready || bus.o_rsp_valid !== exp_rsp_valid || o_paused !== exp_paused || o_busy !== exp_busy) begin
        errors++;
        $display("FAIL pause_seq cyc %0d: ready=%b rsp_v=%b paused=%b busy=%b required %b %b %b %b",
                 i, bus.o_req_ready, bus.o_rsp_valid, o_paused, o_busy, exp_ready, exp_rsp_valid, exp_paused, exp_busy);
      end
      if (i == 1) begin
        checks++;
        if (bus.o_req_ready !== 4'b0000 || bus.o_rsp_valid !== 4'b0001 || bus.o_rsp_data !== 16'd123) begin
          errors++;
          $display("FAIL pause_drain: ready=%b rsp_v=%b data=%0d required 0000 0001 123", bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_data);
        end
      end
      if (i == 3) begin
        checks++;
        if (o_paused !== 1'b1) begin
          errors++;
          $display("FAIL pause_paused: got %b required 1", o_paused);
        end
      end
      if (i == 5) begin
        checks++;
        if (bus.o_req_ready !== 4'b0001) begin
          errors++;
          $display("FAIL pause_resume: ready=%b required 0001", bus.o_req_ready);
        end
      end
      $display("pause cyc %0d: pause=%b ready=%b paused=%b", i, pz[i], bus.o_req_ready, o_paused);
    end
  endtask

  task automatic test_wrap_en();
    apply_reset();
    td_a[2] = 16'hFFFF; td_b[2] = 16'd2;
    drive(4'b0100, 1'b1, 1'b0);
    checks++;
    if (bus.o_req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_grant: ready=%b required 0100", bus.o_req_ready);
    end
    drive(4'b0000, 1'b0, 1'b0);
    checks++;
    if (bus.o_add_en !== 1'b1 || bus.o_rsp_valid !== 4'b0100 || bus.o_rsp_data !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_rsp: add_en=%b rsp_v=%b data=%h required 1 0100 0001", bus.o_add_en, bus.o_rsp_valid, bus.o_rsp_data);
    end
    drive(4'b0000, 1'b0, 1'b0);
    checks++;
    if (bus.o_add_en !== 1'b0) begin
      errors++;
      $display("FAIL wrap_en_idle: add_en=%b required 0", bus.o_add_en);
    end
    $display("test_wrap_en done: data=%h", bus.o_rsp_data);
  endtask

  task automatic test_error();
    apply_reset();
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    td_spur = 1'b1;
    drive(4'b0000, 1'b1, 1'b0);
    td_spur = 1'b0;
    checks++;
    if (bus.o_rsp_valid !== 4'b0000 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_spur_cycle: rsp_v=%b err=%b required 0000 0", bus.o_rsp_valid, o_err);
    end
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b1, 1'b0);
      checks++;
      if (o_err !== 1'b1 || o_err !== exp_err) begin
        errors++;
        $display("FAIL err_sticky cyc %0d: err=%b required 1", i, o_err);
      end
    end
    td_a[0] = 16'd7; td_b[0] = 16'd9;
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    checks++;
    if (bus.o_rsp_valid !== 4'b0001 || bus.o_rsp_data !== 16'd16) begin
      errors++;
      $display("FAIL err_pre_rst_rsp: rsp_v=%b data=%0d required 0001 16", bus.o_rsp_valid, bus.o_rsp_data);
    end
    rst = 1'b1;
    bus.i_req_valid = '1;
    #1;
    checks++;
    if ({bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_data, bus.o_add_valid, bus.o_add_data_bus,
         bus.o_add_en, o_busy, o_paused, o_err, o_grant_cnt} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: ready=%b rsp_v=%b data=%h add_en=%b busy=%b err=%b cnt=%0d required all 0",
               bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_data, bus.o_add_en, o_busy, o_err, o_grant_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b1, 1'b0);
      checks++;
      if (o_err !== 1'b0 || bus.o_rsp_valid !== 4'b0000 || o_grant_cnt !== 32'd0) begin
        errors++;
        $display("FAIL post_rst cyc %0d: err=%b rsp_v=%b cnt=%0d required 0 0000 0", i, o_err, bus.o_rsp_valid, o_grant_cnt);
      end
    end
    $display("test_error done: err=%b", o_err);
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    bit           en, pause;
    int           pause_len;
    pend = '0; pause_len = 0;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 99) < 45) begin
          pend[k] = 1'b1;
          td_a[k] = 16'($urandom);
          td_b[k] = 16'($urandom);
        end
      end
      en = ($urandom_range(0, 9) != 0);
      if (pause_len > 0) pause_len--;
      else if ($urandom_range(0, 24) == 0) pause_len = $urandom_range(1, 6);
      pause = (pause_len > 0);
      drive(pend, en, pause);
      checks++;
      if ({bus.o_req_ready, bus.o_rsp_valid, bus.o_add_valid, bus.o_add_en, o_busy, o_paused, o_err, o_grant_cnt} !==
          {exp_ready, exp_rsp_valid, exp_add_valid, exp_add_en, exp_busy, exp_paused, exp_err, exp_cnt}) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d: ready=%b rsp_v=%b add_v=%b add_en=%b busy=%b paused=%b err=%b cnt=%0d required %b %b %b %b %b %b %b %0d",
                 cyc, bus.o_req_ready, bus.o_rsp_valid, bus.o_add_valid, bus.o_add_en, o_busy, o_paused, o_err, o_grant_cnt,
                 exp_ready, exp_rsp_valid, exp_add_valid, exp_add_en, exp_busy, exp_paused, exp_err, exp_cnt);
      end
      checks++;
      if (bus.o_add_data_bus !== exp_add_data || (exp_rsp_valid != '0 && bus.o_rsp_data !== exp_rsp_data)) begin
        errors++;
        $display("FAIL rand_data cyc %0d: add_data=%h rsp_data=%h required %h %h", cyc, bus.o_add_data_bus, bus.o_rsp_data, exp_add_data, exp_rsp_data);
      end
      if (cyc % 50 == 0) $display("rand cyc %0d: req=%b ready=%b rsp_v=%b paused=%b", cyc, pend, bus.o_req_ready, bus.o_rsp_valid, o_paused);
      if (exp_grant) pend[exp_win] = 1'b0;
    end
  endtask

  initial begin
    td_v = '0; td_spur = 1'b0;
    for (int k = 0; k < N; k++) begin
      td_a[k] = '0; td_b[k] = '0;
    end
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    model_reset();
    test_reset();
    test_single();
    test_all_rr();
    test_sparse();
    test_pause();
    test_wrap_en();
    test_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
